// File: rtl/axilite_reg_slave.sv
// AXI4-lite responder for a bank of 32-bit control/status registers.
// Register 0 is a read-only ID word; the rest are exposed on reg_out with per-register write pulses.
module axilite_reg_slave #(
   parameter int          NUM_REGS = 16,
   parameter logic [31:0] ID_VALUE = 32'h0000_0000
) (
   input  logic                     s_axi_aclk,
   input  logic                     s_axi_areset,
   input  logic [31:0]              s_axi_awaddr,
   input  logic [2:0]               s_axi_awprot,
   input  logic                     s_axi_awvalid,
   output logic                     s_axi_awready,
   input  logic [31:0]              s_axi_wdata,
   input  logic [3:0]               s_axi_wstrb,
   input  logic                     s_axi_wvalid,
   output logic                     s_axi_wready,
   output logic [1:0]               s_axi_bresp,
   output logic                     s_axi_bvalid,
   input  logic                     s_axi_bready,
   input  logic [31:0]              s_axi_araddr,
   input  logic [2:0]               s_axi_arprot,
   input  logic                     s_axi_arvalid,
   output logic                     s_axi_arready,
   output logic [31:0]              s_axi_rdata,
   output logic [1:0]               s_axi_rresp,
   output logic                     s_axi_rvalid,
   input  logic                     s_axi_rready,
   output logic [32*NUM_REGS-1:0]   reg_out,
   output logic [NUM_REGS-1:0]      wr_pulse
);

   localparam int          IDX_W       = $clog2(NUM_REGS);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   // Write holding slots keep only the word address; byte offset bits are irrelevant.
   logic                  aw_full_q, aw_full_d;
   logic [29:0]           aw_word_q, aw_word_d;
   logic                  w_full_q, w_full_d;
   logic [31:0]           w_data_q, w_data_d;
   logic [3:0]            w_strb_q, w_strb_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  rvalid_q, rvalid_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
   logic [31:0]           regs_q [NUM_REGS];
   logic [31:0]           regs_d [NUM_REGS];

   logic                  aw_hs, w_hs, ar_hs, commit, wr_ok;
   logic [29:0]           cur_word;
   logic [31:0]           cur_data;
   logic [3:0]            cur_strb;
   logic [IDX_W-1:0]      wr_idx, rd_idx;
   logic                  rd_in_range;

   logic unused_bits;
   assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   // Readies are pure functions of state so no valid->ready combinational path exists.
   assign s_axi_awready = !aw_full_q && !bvalid_q;
   assign s_axi_wready  = !w_full_q && !bvalid_q;
   assign s_axi_arready = !rvalid_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign wr_pulse      = wr_pulse_q;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      reg_out = '0;
      reg_out[31:0] = ID_VALUE;
      for (int i = 1; i < NUM_REGS; i++) begin
         reg_out[32*i +: 32] = regs_q[i];
      end
   end

   always_comb begin
      aw_hs    = s_axi_awvalid && s_axi_awready;
      w_hs     = s_axi_wvalid && s_axi_wready;
      ar_hs    = s_axi_arvalid && s_axi_arready;
      cur_word = aw_full_q ? aw_word_q : s_axi_awaddr[31:2];
      cur_data = w_full_q ? w_data_q : s_axi_wdata;
      cur_strb = w_full_q ? w_strb_q : s_axi_wstrb;
      commit   = (aw_full_q || aw_hs) && (w_full_q || w_hs);
      wr_idx   = cur_word[IDX_W-1:0];
      wr_ok    = (cur_word[29:IDX_W] == '0) && (wr_idx != '0);
      rd_idx      = s_axi_araddr[IDX_W+1:2];
      rd_in_range = (s_axi_araddr[31:IDX_W+2] == '0);

      aw_full_d  = aw_full_q;
      aw_word_d  = aw_word_q;
      w_full_d   = w_full_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      rvalid_d   = rvalid_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      wr_pulse_d = '0;
      regs_d     = regs_q;

      if (aw_hs) begin
         aw_full_d = 1'b1;
         aw_word_d = s_axi_awaddr[31:2];
      end
      if (w_hs) begin
         w_full_d = 1'b1;
         w_data_d = s_axi_wdata;
         w_strb_d = s_axi_wstrb;
      end

      if (bvalid_q && s_axi_bready) begin
         bvalid_d = 1'b0;
      end
      if (commit) begin
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
         if (wr_ok) begin
            wr_pulse_d[wr_idx] = 1'b1;
            for (int b = 0; b < 4; b++) begin
               if (cur_strb[b]) regs_d[wr_idx][8*b +: 8] = cur_data[8*b +: 8];
            end
         end
      end

      if (rvalid_q && s_axi_rready) begin
         rvalid_d = 1'b0;
      end
      // Reads sample regs_q, so a read on a commit edge returns the pre-write value.
      if (ar_hs) begin
         rvalid_d = 1'b1;
         if (!rd_in_range) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
         end else if (rd_idx == '0) begin
            rdata_d = ID_VALUE;
            rresp_d = RESP_OKAY;
         end else begin
            rdata_d = regs_q[rd_idx];
            rresp_d = RESP_OKAY;
         end
      end
   end

   always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         aw_full_q  <= 1'b0;
         aw_word_q  <= '0;
         w_full_q   <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
         wr_pulse_q <= '0;
         // NOTE: the register bank is user-visible state that must read 0 after reset, so it is reset too.
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all registers update together.
         aw_full_q  <= aw_full_d;
         aw_word_q  <= aw_word_d;
         w_full_q   <= w_full_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         wr_pulse_q <= wr_pulse_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

endmodule

// File: tb/tb_axilite_reg_slave.sv
// Self-checking bench for axilite_reg_slave: directed scenarios plus randomized traffic
// compared against a word-array model of the register bank.
module tb_axilite_reg_slave;

   localparam int          NUM_REGS = 16;
   localparam logic [31:0] ID_VALUE = 32'hC0DE_0A11;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic [31:0]             s_axi_awaddr = '0;
   logic [2:0]              s_axi_awprot = '0;
   logic                    s_axi_awvalid = 1'b0;
   logic                    s_axi_awready;
   logic [31:0]             s_axi_wdata = '0;
   logic [3:0]              s_axi_wstrb = '0;
   logic                    s_axi_wvalid = 1'b0;
   logic                    s_axi_wready;
   logic [1:0]              s_axi_bresp;
   logic                    s_axi_bvalid;
   logic                    s_axi_bready = 1'b0;
   logic [31:0]             s_axi_araddr = '0;
   logic [2:0]              s_axi_arprot = '0;
   logic                    s_axi_arvalid = 1'b0;
   logic                    s_axi_arready;
   logic [31:0]             s_axi_rdata;
   logic [1:0]              s_axi_rresp;
   logic                    s_axi_rvalid;
   logic                    s_axi_rready = 1'b0;
   logic [32*NUM_REGS-1:0]  reg_out;
   logic [NUM_REGS-1:0]     wr_pulse;

   int errors = 0;
   int checks = 0;
   logic [31:0] model [NUM_REGS];

   axilite_reg_slave #(.NUM_REGS(NUM_REGS), .ID_VALUE(ID_VALUE)) dut (
      .s_axi_aclk(clk), .s_axi_areset(rst),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .reg_out(reg_out), .wr_pulse(wr_pulse)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
      $fatal(1);
   end

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic void model_clear();
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
   endfunction

   function automatic logic [32*NUM_REGS-1:0] exp_reg_out();
      logic [32*NUM_REGS-1:0] v;
      for (int i = 0; i < NUM_REGS; i++) v[32*i +: 32] = (i == 0) ? ID_VALUE : model[i];
      return v;
   endfunction

   function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                       input logic [3:0] strb, output logic [1:0] resp,
                                       output logic [NUM_REGS-1:0] pulse);
      int idx;
      idx   = int'(addr / 4);
      pulse = '0;
      if (addr >= 4 * NUM_REGS || idx == 0) begin
         resp = 2'b10;
      end else begin
         resp       = 2'b00;
         pulse[idx] = 1'b1;
         for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
      end
   endfunction

   function automatic void model_read(input logic [31:0] addr, output logic [31:0] data,
                                      output logic [1:0] resp);
      if (addr >= 4 * NUM_REGS) begin
         data = '0;
         resp = 2'b10;
      end else if (addr / 4 == 0) begin
         data = ID_VALUE;
         resp = 2'b00;
      end else begin
         data = model[addr / 4];
         resp = 2'b00;
      end
   endfunction

   // One write: AW presented after aw_lag cycles, W after w_lag, bready held low b_hold cycles.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_lag, input int w_lag, input int b_hold, input string tag);
      logic aw_done, w_done, aw_fire, w_fire, got;
      logic [1:0] exp_resp;
      logic [NUM_REGS-1:0] exp_pulse;
      aw_done = 1'b0;
      w_done  = 1'b0;
      got     = 1'b0;
      s_axi_awaddr = addr;
      s_axi_wdata  = data;
      s_axi_wstrb  = strb;
      s_axi_bready = 1'b0;
      for (int cyc = 0; cyc < 40 && !got; cyc++) begin
         s_axi_awvalid = !aw_done && (cyc >= aw_lag);
         s_axi_wvalid  = !w_done && (cyc >= w_lag);
         aw_fire = s_axi_awvalid && s_axi_awready;
         w_fire  = s_axi_wvalid && s_axi_wready;
         tick();
         aw_done = aw_done | aw_fire;
         w_done  = w_done | w_fire;
         if (aw_done && w_done) begin
            got = 1'b1;
         end else if (aw_done || w_done) begin
            checks++;
            if (s_axi_bvalid !== 1'b0 || s_axi_awready !== !aw_done || s_axi_wready !== !w_done) begin
               errors++;
               $display("FAIL %s half_accepted: bvalid=%b awready=%b wready=%b, required bvalid=0 awready=%b wready=%b",
                        tag, s_axi_bvalid, s_axi_awready, s_axi_wready, !aw_done, !w_done);
            end
         end
      end
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s accept_timeout: aw_done=%b w_done=%b, required both accepted", tag, aw_done, w_done);
         return;
      end
      model_write(addr, data, strb, exp_resp, exp_pulse);
      checks++;
      if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== exp_resp || wr_pulse !== exp_pulse) begin
         errors++;
         $display("FAIL %s b_response: bvalid=%b bresp=%b wr_pulse=%h, required bvalid=1 bresp=%b wr_pulse=%h",
                  tag, s_axi_bvalid, s_axi_bresp, wr_pulse, exp_resp, exp_pulse);
      end
      for (int k = 0; k < b_hold; k++) begin
         tick();
         checks++;
         if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== exp_resp || s_axi_awready !== 1'b0 ||
             s_axi_wready !== 1'b0 || wr_pulse !== '0) begin
            errors++;
            $display("FAIL %s b_stall: bvalid=%b bresp=%b awready=%b wready=%b pulse=%h, required 1 %b 0 0 0",
                     tag, s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_wready, wr_pulse, exp_resp);
         end
      end
      s_axi_bready = 1'b1;
      tick();
      s_axi_bready = 1'b0;
      checks++;
      if (s_axi_bvalid !== 1'b0 || wr_pulse !== '0 || reg_out !== exp_reg_out()) begin
         errors++;
         $display("FAIL %s after_b: bvalid=%b wr_pulse=%h reg_out=%h, required bvalid=0 pulse=0 reg_out=%h",
                  tag, s_axi_bvalid, wr_pulse, reg_out, exp_reg_out());
      end
   endtask

   task automatic axi_read(input logic [31:0] addr, input string tag);
      logic fire;
      logic [31:0] exp_data;
      logic [1:0] exp_resp;
      fire = 1'b0;
      s_axi_araddr  = addr;
      s_axi_rready  = 1'b0;
      for (int cyc = 0; cyc < 20 && !fire; cyc++) begin
         s_axi_arvalid = 1'b1;
         fire = s_axi_arready;
         tick();
      end
      s_axi_arvalid = 1'b0;
      model_read(addr, exp_data, exp_resp);
      checks++;
      if (!fire || s_axi_rvalid !== 1'b1 || s_axi_rdata !== exp_data || s_axi_rresp !== exp_resp) begin
         errors++;
         $display("FAIL %s read: accepted=%b rvalid=%b rdata=%h rresp=%b, required 1 1 %h %b",
                  tag, fire, s_axi_rvalid, s_axi_rdata, s_axi_rresp, exp_data, exp_resp);
      end
      s_axi_rready = 1'b1;
      tick();
      s_axi_rready = 1'b0;
      checks++;
      if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
         errors++;
         $display("FAIL %s r_release: rvalid=%b arready=%b, required 0 1", tag, s_axi_rvalid, s_axi_arready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_clear();
      repeat (2) tick();
      rst = 1'b0;
      tick();
      checks++;
      if (s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1 || s_axi_arready !== 1'b1 ||
          s_axi_bvalid !== 1'b0 || s_axi_rvalid !== 1'b0 || s_axi_bresp !== 2'b00 ||
          s_axi_rresp !== 2'b00 || s_axi_rdata !== 32'h0 || wr_pulse !== '0) begin
         errors++;
         $display("FAIL reset_outputs: aw/w/ar ready=%b%b%b bvalid=%b rvalid=%b bresp=%b rresp=%b rdata=%h pulse=%h, required 111 0 0 00 00 0 0",
                  s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
                  s_axi_bresp, s_axi_rresp, s_axi_rdata, wr_pulse);
      end
      checks++;
      if (reg_out !== exp_reg_out()) begin
         errors++;
         $display("FAIL reset_regs: reg_out=%h, required %h", reg_out, exp_reg_out());
      end
   endtask

   task automatic test_basic_write();
      axi_write(32'h04, 32'hDEAD_BEEF, 4'b1111, 0, 0, 0, "basic_w");
      checks++;
      if (reg_out[63:32] !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL basic_reg1: reg_out[63:32]=%h, required deadbeef", reg_out[63:32]);
      end
      axi_read(32'h04, "basic_r");
   endtask

   task automatic test_w_first();
      axi_write(32'h08, 32'h1122_3344, 4'b0101, 3, 0, 0, "w_first");
      checks++;
      if (reg_out[95:64] !== 32'h0022_0044) begin
         errors++;
         $display("FAIL w_first_reg2: reg_out[95:64]=%h, required 00220044", reg_out[95:64]);
      end
   endtask

   task automatic test_errors();
      axi_write(32'h00, 32'hFFFF_FFFF, 4'b1111, 0, 0, 0, "err_w_id");
      axi_write(32'h40, 32'hFFFF_FFFF, 4'b1111, 1, 0, 0, "err_w_oor");
      axi_read(32'h00, "err_r_id");
      axi_read(32'h40, "err_r_oor");
      axi_write(32'h1D, 32'hA5A5_0000, 4'b0000, 0, 2, 0, "zero_strb");
   endtask

   task automatic test_bready_stall();
      logic [1:0] r;
      logic [NUM_REGS-1:0] p;
      axi_write(32'h10, 32'h0BAD_CAFE, 4'b1111, 0, 0, 0, "stall_pre");
      s_axi_awaddr = 32'h24; s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'b1111;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      tick();
      model_write(32'h24, 32'h1234_5678, 4'b1111, r, p);
      // The second write is presented throughout the stall and must not be taken.
      s_axi_awaddr = 32'h28; s_axi_wdata = 32'h5555_AAAA;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00 || s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: bvalid=%b bresp=%b awready=%b wready=%b, required 1 00 0 0",
                     s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_wready);
         end
      end
      s_axi_bready = 1'b1;
      tick();
      s_axi_bready = 1'b0;
      checks++;
      if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1 || reg_out !== exp_reg_out()) begin
         errors++;
         $display("FAIL stall_release: bvalid=%b awready=%b wready=%b reg_out=%h, required 0 1 1 %h",
                  s_axi_bvalid, s_axi_awready, s_axi_wready, reg_out, exp_reg_out());
      end
      tick();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      model_write(32'h28, 32'h5555_AAAA, 4'b1111, r, p);
      checks++;
      if (s_axi_bvalid !== 1'b1 || wr_pulse !== p) begin
         errors++;
         $display("FAIL stall_next: bvalid=%b wr_pulse=%h, required 1 %h", s_axi_bvalid, wr_pulse, p);
      end
      s_axi_bready = 1'b1;
      tick();
      s_axi_bready = 1'b0;
      checks++;
      if (reg_out !== exp_reg_out()) begin
         errors++;
         $display("FAIL stall_next_regs: reg_out=%h, required %h", reg_out, exp_reg_out());
      end
   endtask

   task automatic test_read_stall();
      logic [31:0] old_val, new_val, old5;
      logic [1:0] r;
      logic [NUM_REGS-1:0] p;
      old_val = model[3];
      new_val = $urandom;
      s_axi_araddr = 32'h0C; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
      tick();
      s_axi_arvalid = 1'b0;
      axi_write(32'h0C, new_val, 4'b1111, 1, 0, 1, "rstall_w");
      checks++;
      if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== old_val || s_axi_rresp !== 2'b00) begin
         errors++;
         $display("FAIL rstall_hold: rvalid=%b rdata=%h rresp=%b, required 1 %h 00",
                  s_axi_rvalid, s_axi_rdata, s_axi_rresp, old_val);
      end
      s_axi_rready = 1'b1;
      tick();
      s_axi_rready = 1'b0;
      axi_read(32'h0C, "rstall_new");
      // Read and write to the same register accepted on the same edge.
      old5 = model[5];
      s_axi_awaddr = 32'h14; s_axi_wdata = ~old5; s_axi_wstrb = 4'b1111;
      s_axi_araddr = 32'h14;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
      tick();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      model_write(32'h14, ~old5, 4'b1111, r, p);
      checks++;
      if (s_axi_bvalid !== 1'b1 || s_axi_rvalid !== 1'b1 || s_axi_rdata !== old5) begin
         errors++;
         $display("FAIL same_edge: bvalid=%b rvalid=%b rdata=%h, required 1 1 %h",
                  s_axi_bvalid, s_axi_rvalid, s_axi_rdata, old5);
      end
      s_axi_bready = 1'b1; s_axi_rready = 1'b1;
      tick();
      s_axi_bready = 1'b0; s_axi_rready = 1'b0;
      axi_read(32'h14, "same_edge_new");
   endtask

   task automatic test_back_to_back();
      int aw_cnt, ar_cnt;
      logic [1:0] r;
      logic [NUM_REGS-1:0] p;
      aw_cnt = 0; ar_cnt = 0;
      s_axi_awaddr = 32'h1C; s_axi_wdata = 32'h0F0F_1234; s_axi_wstrb = 4'b1111;
      s_axi_araddr = 32'h04;
      s_axi_bready = 1'b1; s_axi_rready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
         if (s_axi_awready && s_axi_wready) aw_cnt++;
         if (s_axi_arready) ar_cnt++;
         tick();
      end
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      tick();
      s_axi_bready = 1'b0; s_axi_rready = 1'b0;
      model_write(32'h1C, 32'h0F0F_1234, 4'b1111, r, p);
      checks++;
      if (aw_cnt !== 4 || ar_cnt !== 4 || s_axi_bvalid !== 1'b0 || s_axi_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL back_to_back: writes=%0d reads=%0d bvalid=%b rvalid=%b, required 4 4 0 0",
                  aw_cnt, ar_cnt, s_axi_bvalid, s_axi_rvalid);
      end
      checks++;
      if (reg_out !== exp_reg_out()) begin
         errors++;
         $display("FAIL back_to_back_regs: reg_out=%h, required %h", reg_out, exp_reg_out());
      end
   endtask

   task automatic test_reset_midflight();
      s_axi_awaddr = 32'h08; s_axi_awvalid = 1'b1;
      tick();
      s_axi_awvalid = 1'b0;
      s_axi_araddr = 32'h04; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
      tick();
      s_axi_arvalid = 1'b0;
      checks++;
      if (s_axi_awready !== 1'b0 || s_axi_rvalid !== 1'b1) begin
         errors++;
         $display("FAIL midflight_pre: awready=%b rvalid=%b, required 0 1", s_axi_awready, s_axi_rvalid);
      end
      #2 rst = 1'b1;
      model_clear();
      #1;
      checks++;
      if (s_axi_rvalid !== 1'b0 || s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1 ||
          s_axi_wready !== 1'b1 || s_axi_arready !== 1'b1 || reg_out !== exp_reg_out()) begin
         errors++;
         $display("FAIL midflight_reset: rvalid=%b bvalid=%b readies=%b%b%b reg_out=%h, required 0 0 111 %h",
                  s_axi_rvalid, s_axi_bvalid, s_axi_awready, s_axi_wready, s_axi_arready, reg_out, exp_reg_out());
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
      axi_write(32'h18, 32'h7777_8888, 4'b1111, 3, 0, 0, "post_reset_w");
      axi_read(32'h08, "post_reset_r2");
      axi_read(32'h18, "post_reset_r6");
   endtask

   task automatic test_random();
      logic [31:0] addr, data;
      int sel;
      for (int it = 0; it < 30; it++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0)      addr = $urandom_range(4 * NUM_REGS, 255);
         else if (sel == 1) addr = 32'h8000_0000 | $urandom;
         else               addr = $urandom_range(0, 4 * NUM_REGS - 1);
         data = $urandom;
         axi_write(addr, data, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 2), "rand_w");
         axi_read(addr, "rand_rb");
         axi_read($urandom_range(0, 4 * NUM_REGS + 7), "rand_r");
      end
   endtask

   initial begin
      test_reset();
      test_basic_write();
      test_w_first();
      test_errors();
      test_bready_stall();
      test_read_stall();
      test_back_to_back();
      test_reset_midflight();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
